pdp11_timer_bank: RTL and testbench



---
 rtl/pdp11_timer_bank.sv | 190 +++++++++++++++++++
 tb/tb_pdp11_timer_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_timer_bank.sv
// pdp11_timer_bank: NUM_TIMERS prescaled timer/counter channels on the PDP-11
// I/O bus. Each channel has an 8-word register window; STATUS sits right after
// the last window and exposes the pending bits (write-1-to-clear).

// One timer channel: config registers, prescaler, counter, pending and waveform.
module pdp11_timer_chan #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_pre,
  input  logic             i_wr_top,
  input  logic             i_wr_cnt,
  input  logic             i_wr_cmp,
  input  logic [15:0]      i_wdata,
  input  logic             i_clr,
  output logic [4:0]       o_ctrl,
  output logic [WIDTH-1:0] o_pre,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_cmp,
  output logic             o_pend,
  output logic             o_tout
);
  localparam logic [WIDTH:0] ONE_X = 1;
  localparam logic [WIDTH-1:0] ONE = 1;

  logic             r_en, r_os, r_ie;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_pre, r_top, r_cnt, r_cmp, r_pctr;
  logic             r_pend, r_tog, r_pulse;
  logic             w_tick, w_wrap, w_start;

  // Extra bit so pre_ctr+1 cannot overflow the comparison.
  assign w_tick  = r_en && (({1'b0, r_pctr} + ONE_X) >= {1'b0, r_pre});
  // A CNT write in the same cycle overrides the wrap.
  assign w_wrap  = w_tick && (r_cnt >= r_top) && !i_wr_cnt;
  assign w_start = i_wr_ctrl && i_wdata[0] && !r_en;

  // Software-visible configuration; one-shot wrap drops EN unless CTRL is written.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0; r_os <= 1'b0; r_ie <= 1'b0; r_mode <= 2'b00;
      r_pre <= '0; r_top <= '1; r_cmp <= '0;
    end else begin
      if (i_wr_ctrl) begin
        r_en   <= i_wdata[0];
        r_os   <= i_wdata[1];
        r_ie   <= i_wdata[2];
        r_mode <= i_wdata[4:3];
      end else if (w_wrap && r_os) begin
        r_en <= 1'b0;
      end
      if (i_wr_pre) r_pre <= i_wdata[WIDTH-1:0];
      if (i_wr_top) r_top <= i_wdata[WIDTH-1:0];
      if (i_wr_cmp) r_cmp <= i_wdata[WIDTH-1:0];
    end
  end

  // Prescaler and main counter; both freeze while disabled.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_pctr <= '0;
      r_cnt  <= '0;
    end else if (i_wr_cnt) begin
      r_pctr <= '0;
      r_cnt  <= i_wdata[WIDTH-1:0];
    end else begin
      if (w_start)   r_pctr <= '0;
      else if (r_en) r_pctr <= w_tick ? '0 : r_pctr + ONE;
      if (w_tick)    r_cnt  <= w_wrap ? '0 : r_cnt + ONE;
    end
  end

  // Wrap events: pending (set beats clear), toggle flop, one-cycle pulse.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_tog   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      if (w_wrap)     r_pend <= 1'b1;
      else if (i_clr) r_pend <= 1'b0;
      if (i_wr_ctrl && (i_wdata[4:3] != 2'b01)) r_tog <= 1'b0;
      else if (w_wrap && (r_mode == 2'b01))     r_tog <= ~r_tog;
      r_pulse <= w_wrap;
    end
  end

  // Waveform select.
  always_comb begin
    o_tout = 1'b0;
    case (r_mode)
      2'b01:   o_tout = r_tog;
      2'b10:   o_tout = (r_cnt < r_cmp);
      2'b11:   o_tout = r_pulse;
      default: o_tout = 1'b0;
    endcase
  end

  assign o_ctrl = {r_mode, r_ie, r_os, r_en};
  assign o_pre  = r_pre;
  assign o_top  = r_top;
  assign o_cnt  = r_cnt;
  assign o_cmp  = r_cmp;
  assign o_pend = r_pend;
endmodule

// Bank top: address decode, channel array, STATUS and registered read port.
module pdp11_timer_bank #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned WIDTH      = 16,
  parameter logic [7:0]  BASE_ADDR  = 8'h40
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n,
  input  logic [7:0]            io_addr,
  input  logic [15:0]           io_out,
  input  logic                  io_wen,
  output logic [15:0]           io_rdata,
  input  logic [NUM_TIMERS-1:0] int_ack,
  output logic [NUM_TIMERS-1:0] irq,
  output logic [NUM_TIMERS-1:0] tmr_out
);
  localparam logic [7:0] STAT_ADDR = 8'(BASE_ADDR + 8 * NUM_TIMERS);

  logic [7:0]                       w_off;
  logic [2:0]                       w_k;
  logic                             w_in_win, w_stat;
  logic [NUM_TIMERS-1:0]            w_sel, w_wr, w_clr, w_pend;
  logic [NUM_TIMERS-1:0][4:0]       w_ctrl;
  logic [NUM_TIMERS-1:0][WIDTH-1:0] w_pre, w_top, w_cnt, w_cmp;
  logic [15:0]                      w_rd;

  assign w_off    = io_addr - BASE_ADDR;
  assign w_k      = w_off[2:0];
  assign w_in_win = (io_addr >= BASE_ADDR) && (io_addr < STAT_ADDR);
  assign w_stat   = (io_addr == STAT_ADDR);

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    assign w_sel[g] = w_in_win && (w_off[7:3] == 5'(g));
    assign w_wr[g]  = io_wen && w_sel[g];
    assign w_clr[g] = int_ack[g] | (io_wen && w_stat && io_out[g]);
    assign irq[g]   = w_pend[g] & w_ctrl[g][2];

    pdp11_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .wb_clk_i (wb_clk_i),
      .rst_n    (rst_n),
      .i_wr_ctrl(w_wr[g] && (w_k == 3'd0)),
      .i_wr_pre (w_wr[g] && (w_k == 3'd1)),
      .i_wr_top (w_wr[g] && (w_k == 3'd2)),
      .i_wr_cnt (w_wr[g] && (w_k == 3'd3)),
      .i_wr_cmp (w_wr[g] && (w_k == 3'd4)),
      .i_wdata  (io_out),
      .i_clr    (w_clr[g]),
      .o_ctrl   (w_ctrl[g]),
      .o_pre    (w_pre[g]),
      .o_top    (w_top[g]),
      .o_cnt    (w_cnt[g]),
      .o_cmp    (w_cmp[g]),
      .o_pend   (w_pend[g]),
      .o_tout   (tmr_out[g])
    );
  end

  // Read mux; anything not decoded reads all ones.
  always_comb begin
    w_rd = 16'hFFFF;
    if (w_stat) w_rd = 16'(w_pend);
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (w_sel[i]) begin
        case (w_k)
          3'd0:    w_rd = 16'(w_ctrl[i]);
          3'd1:    w_rd = 16'(w_pre[i]);
          3'd2:    w_rd = 16'(w_top[i]);
          3'd3:    w_rd = 16'(w_cnt[i]);
          3'd4:    w_rd = 16'(w_cmp[i]);
          default: w_rd = 16'hFFFF;
        endcase
      end
    end
  end

  // Registered read data, held across write cycles.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)       io_rdata <= '0;
    else if (!io_wen) io_rdata <= w_rd;
  end
endmodule

// File: tb/tb_pdp11_timer_bank.sv
// Bench for pdp11_timer_bank: directed scenarios with closed-form expectations,
// then random bus traffic against a per-cycle reference model.
module tb_pdp11_timer_bank;
  localparam int N    = 4;
  localparam int BASE = 'h40;
  localparam int STAT = BASE + 8 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    io_addr = '0;
  logic [15:0]   io_out = '0;
  logic          io_wen = 1'b0;
  logic [N-1:0]  int_ack = '0;
  logic [15:0]   io_rdata;
  logic [N-1:0]  irq, tmr_out;
  logic [15:0]   rdata8;
  logic [0:0]    ack8 = '0;
  logic [0:0]    irq8, tout8;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pdp11_timer_bank dut (
    .wb_clk_i(clk), .rst_n(rst_n), .io_addr(io_addr), .io_out(io_out),
    .io_wen(io_wen), .io_rdata(io_rdata), .int_ack(int_ack), .irq(irq),
    .tmr_out(tmr_out)
  );

  pdp11_timer_bank #(.NUM_TIMERS(1), .WIDTH(8), .BASE_ADDR(8'h80)) dut8 (
    .wb_clk_i(clk), .rst_n(rst_n), .io_addr(io_addr), .io_out(io_out),
    .io_wen(io_wen), .io_rdata(rdata8), .int_ack(ack8), .irq(irq8),
    .tmr_out(tout8)
  );

  // ---------------- reference model (16-bit channels) ----------------
  int m_ctrl[N], m_pre[N], m_top[N], m_cnt[N], m_cmp[N], m_pc[N];
  bit m_pend[N], m_tog[N], m_pul[N];
  int m_rd;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_ctrl[c] = 0; m_pre[c] = 0; m_top[c] = 'hFFFF; m_cnt[c] = 0;
      m_cmp[c] = 0; m_pc[c] = 0; m_pend[c] = 0; m_tog[c] = 0; m_pul[c] = 0;
    end
    m_rd = 0;
  endtask

  function automatic int m_read(int a);
    int s;
    s = 'hFFFF;
    if (a == STAT) begin
      s = 0;
      for (int c = 0; c < N; c++) s = s | (int'(m_pend[c]) << c);
    end else if (a >= BASE && a < STAT) begin
      case ((a - BASE) % 8)
        0: s = m_ctrl[(a - BASE) / 8];
        1: s = m_pre[(a - BASE) / 8];
        2: s = m_top[(a - BASE) / 8];
        3: s = m_cnt[(a - BASE) / 8];
        4: s = m_cmp[(a - BASE) / 8];
        default: s = 'hFFFF;
      endcase
    end
    return s;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int a, d, k, mode;
    bit hit, tick, wrap, clr, wcnt, wctrl;
    a = int'(io_addr); d = int'(io_out);
    if (!io_wen) m_rd = m_read(a);
    for (int c = 0; c < N; c++) begin
      hit   = io_wen && a >= BASE && a < STAT && ((a - BASE) / 8 == c);
      k     = (a - BASE) % 8;
      wctrl = hit && k == 0;
      wcnt  = hit && k == 3;
      mode  = (m_ctrl[c] >> 3) & 3;
      tick  = (m_ctrl[c] & 1) && (m_pc[c] + 1 >= m_pre[c]);
      wrap  = tick && m_cnt[c] >= m_top[c] && !wcnt;
      clr   = int_ack[c] || (io_wen && a == STAT && ((d >> c) & 1));
      if (wctrl && (((d >> 3) & 3) != 1)) m_tog[c] = 0;
      else if (wrap && mode == 1)         m_tog[c] = !m_tog[c];
      m_pul[c] = wrap;
      if (wrap) m_pend[c] = 1; else if (clr) m_pend[c] = 0;
      if (wcnt) begin
        m_cnt[c] = d; m_pc[c] = 0;
      end else begin
        if (wctrl && (d & 1) && !(m_ctrl[c] & 1)) m_pc[c] = 0;
        else if (m_ctrl[c] & 1) m_pc[c] = tick ? 0 : m_pc[c] + 1;
        if (tick) m_cnt[c] = wrap ? 0 : m_cnt[c] + 1;
      end
      if (wctrl) m_ctrl[c] = d & 'h1F;
      else if (wrap && (m_ctrl[c] & 2)) m_ctrl[c] = m_ctrl[c] & ~1;
      if (hit && k == 1) m_pre[c] = d;
      if (hit && k == 2) m_top[c] = d;
      if (hit && k == 4) m_cmp[c] = d;
    end
  endtask

  function automatic logic [N-1:0] m_irq();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = m_pend[c] && ((m_ctrl[c] >> 2) & 1);
    return r;
  endfunction

  function automatic logic [N-1:0] m_tout();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++)
      case ((m_ctrl[c] >> 3) & 3)
        1: r[c] = m_tog[c];
        2: r[c] = m_cnt[c] < m_cmp[c];
        3: r[c] = m_pul[c];
        default: r[c] = 1'b0;
      endcase
    return r;
  endfunction

  // ---------------- bus helpers (enter and leave on a falling edge) ----------------
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    io_addr = 8'(a); io_out = 16'(d); io_wen = 1'b1;
    tick();
    io_wen = 1'b0;
  endtask

  task automatic rd(input int a, output logic [15:0] d);
    io_addr = 8'(a); io_wen = 1'b0;
    tick();
    d = io_rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] d;
    n_chk++; if (irq !== '0)      begin n_fail++; $display("FAIL rst_irq got %h exp %h", irq, 4'h0); end
    n_chk++; if (tmr_out !== '0)  begin n_fail++; $display("FAIL rst_tout got %h exp %h", tmr_out, 4'h0); end
    n_chk++; if (io_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata got %h exp %h", io_rdata, 16'h0); end
    wr(BASE + 1, 2); wr(BASE + 2, 5); wr(BASE + 0, 'h0D);
    repeat (13) tick();
    rd(BASE + 1, d);
    n_chk++; if (irq[0] !== 1'b1 || d !== 16'd2) begin n_fail++; $display("FAIL prerst got irq=%b rd=%h exp irq=1 rd=0002", irq[0], d); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (irq !== '0 || tmr_out !== '0 || io_rdata !== '0) begin
      n_fail++; $display("FAIL midrst got irq=%h tout=%h rd=%h exp all 0", irq, tmr_out, io_rdata);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(BASE + 2, d);
    n_chk++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL rst_top got %h exp %h", d, 16'hFFFF); end
    rd(BASE + 0, d);
    n_chk++; if (d !== 16'h0) begin n_fail++; $display("FAIL rst_ctrl got %h exp %h", d, 16'h0); end
  endtask

  task automatic test_toggle();
    int n;
    wr(BASE + 1, 4); wr(BASE + 2, 3); wr(BASE + 0, 'h0D);
    n = 0;
    do begin tick(); n++; end while (irq[0] !== 1'b1 && n < 40);
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL tog_first got %0d exp %0d", n, 16); end
    n_chk++; if (tmr_out[0] !== 1'b1) begin n_fail++; $display("FAIL tog_hi got %b exp 1", tmr_out[0]); end
    int_ack = 4'b0001; tick(); int_ack = '0;
    n_chk++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL tog_ack got %b exp 0", irq[0]); end
    n = 0;
    do begin tick(); n++; end while (irq[0] !== 1'b1 && n < 40);
    n_chk++; if (n != 15) begin n_fail++; $display("FAIL tog_period got %0d exp %0d", n, 15); end
    n_chk++; if (tmr_out[0] !== 1'b0) begin n_fail++; $display("FAIL tog_lo got %b exp 0", tmr_out[0]); end
    int_ack = 4'b0001; tick(); int_ack = '0;
    wr(BASE + 0, 0);
  endtask

  task automatic test_oneshot();
    int n; bit extra; logic [15:0] d;
    wr(BASE + 9, 1); wr(BASE + 10, 9); wr(BASE + 8, 'h07);
    n = 0;
    do begin tick(); n++; end while (irq[1] !== 1'b1 && n < 40);
    n_chk++; if (n != 10) begin n_fail++; $display("FAIL os_delay got %0d exp %0d", n, 10); end
    int_ack = 4'b0010; tick(); int_ack = '0;
    extra = 0;
    repeat (30) begin tick(); if (irq[1] !== 1'b0) extra = 1; end
    n_chk++; if (extra) begin n_fail++; $display("FAIL os_extra got irq again exp none"); end
    rd(BASE + 8, d);
    n_chk++; if (d !== 16'h0006) begin n_fail++; $display("FAIL os_ctrl got %h exp %h", d, 16'h0006); end
    rd(BASE + 11, d);
    n_chk++; if (d !== 16'h0) begin n_fail++; $display("FAIL os_cnt got %h exp %h", d, 16'h0); end
  endtask

  task automatic test_pwm();
    int hi;
    wr(BASE + 17, 1); wr(BASE + 18, 7); wr(BASE + 20, 3); wr(BASE + 16, 'h11);
    hi = 0; repeat (16) begin tick(); hi += int'(tmr_out[2]); end
    n_chk++; if (hi != 6) begin n_fail++; $display("FAIL pwm_3of8 got %0d exp %0d", hi, 6); end
    wr(BASE + 20, 0);
    hi = 0; repeat (16) begin tick(); hi += int'(tmr_out[2]); end
    n_chk++; if (hi != 0) begin n_fail++; $display("FAIL pwm_cmp0 got %0d exp %0d", hi, 0); end
    wr(BASE + 20, 8);
    hi = 0; repeat (16) begin tick(); hi += int'(tmr_out[2]); end
    n_chk++; if (hi != 16) begin n_fail++; $display("FAIL pwm_cmp8 got %0d exp %0d", hi, 16); end
    wr(BASE + 16, 0);
  endtask

  task automatic test_bus();
    logic [15:0] d;
    rd(BASE + 5, d);
    n_chk++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL rd_k5 got %h exp %h", d, 16'hFFFF); end
    rd('h10, d);
    n_chk++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL rd_unmap got %h exp %h", d, 16'hFFFF); end
    rd(STAT + 1, d);
    n_chk++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL rd_poststat got %h exp %h", d, 16'hFFFF); end
    wr('h82, 'hABCD);
    io_addr = 8'h82; tick();
    n_chk++; if (rdata8 !== 16'h00CD) begin n_fail++; $display("FAIL w8_top got %h exp %h", rdata8, 16'h00CD); end
    wr(STAT, 'hF);
    for (int c = 0; c < N; c++) begin
      wr(BASE + 8 * c + 2, 0); wr(BASE + 8 * c + 1, 1); wr(BASE + 8 * c, 3);
    end
    repeat (2) tick();
    rd(STAT, d);
    n_chk++; if (d !== 16'h000F) begin n_fail++; $display("FAIL stat_all got %h exp %h", d, 16'h000F); end
    wr(STAT, 'h4);
    rd(STAT, d);
    n_chk++; if (d !== 16'h000B) begin n_fail++; $display("FAIL stat_w1c got %h exp %h", d, 16'h000B); end
    wr(STAT, 'hF);
  endtask

  task automatic test_collision();
    logic [15:0] d;
    wr(BASE + 1, 1); wr(BASE + 2, 4); wr(BASE + 0, 'h05);
    repeat (4) tick();
    int_ack = 4'b0001; tick(); int_ack = '0;
    n_chk++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL col_ack got %b exp 1", irq[0]); end
    wr(BASE + 0, 0); wr(STAT, 'hF);
    wr(BASE + 9, 2); wr(BASE + 10, 5); wr(BASE + 8, 'h01);
    repeat (11) tick();
    wr(BASE + 11, 5);
    rd(BASE + 11, d);
    n_chk++; if (d !== 16'd5) begin n_fail++; $display("FAIL col_cnt got %h exp %h", d, 16'd5); end
    rd(STAT, d);
    n_chk++; if (d !== 16'h0) begin n_fail++; $display("FAIL col_nowrap got %h exp %h", d, 16'h0); end
    wr(BASE + 8, 0); wr(STAT, 'hF);
  endtask

  task automatic test_random();
    int r, c, k, v;
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        c = $urandom_range(0, N - 1); k = $urandom_range(0, 7);
        case (k)
          0: v = ($urandom & 'hFFE0) | $urandom_range(0, 31);
          1: v = $urandom_range(0, 3);
          2: v = $urandom_range(0, 7);
          3, 4: v = $urandom_range(0, 9);
          default: v = $urandom & 'hFFFF;
        endcase
        io_addr = 8'(BASE + 8 * c + k); io_out = 16'(v); io_wen = 1'b1;
      end else if (r == 4) begin
        io_addr = 8'(STAT); io_out = 16'($urandom_range(0, 15)); io_wen = 1'b1;
      end else begin
        io_addr = 8'($urandom_range('h3C, 'h64)); io_wen = 1'b0;
        if (r == 5) int_ack = N'($urandom_range(0, 15));
      end
      tick();
      io_wen = 1'b0; int_ack = '0;
      n_chk++; if (io_rdata !== 16'(m_rd)) begin n_fail++; $display("FAIL rnd_rdata it=%0d got %h exp %h", it, io_rdata, 16'(m_rd)); end
      n_chk++; if (irq !== m_irq()) begin n_fail++; $display("FAIL rnd_irq it=%0d got %h exp %h", it, irq, m_irq()); end
      n_chk++; if (tmr_out !== m_tout()) begin n_fail++; $display("FAIL rnd_tout it=%0d got %h exp %h", it, tmr_out, m_tout()); end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_toggle();
    test_oneshot();
    test_pwm();
    test_bus();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
